// File: rtl/ltl_nfa_monitor_engine_if.sv
// ============================================================================
// Module  : ltl_nfa_monitor_engine_if
// Purpose : Configuration write bus and buffered report-event handshake for
//           ltl_nfa_monitor_engine.
//           master = programming / event-consuming side, slave = engine.
// Signals : cfg_we/cfg_kind/cfg_idx/cfg_word/cfg_wdata  -> config write
//           cfg_err                                      <- write rejected
//           evt_valid/evt_chan/evt_index/evt_overflow    <- report event
//           evt_ready                                    -> event accepted
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface ltl_nfa_monitor_engine_if #(
    parameter int N_STE    = 16,
    parameter int N_REPORT = 4,
    parameter int CNT_W    = 32
);
    localparam int IDX_W = $clog2(N_STE);

    logic                cfg_we;
    logic [1:0]          cfg_kind;
    logic [IDX_W-1:0]    cfg_idx;
    logic [2:0]          cfg_word;
    logic [31:0]         cfg_wdata;
    logic                cfg_err;

    logic                evt_valid;
    logic                evt_ready;
    logic [N_REPORT-1:0] evt_chan;
    logic [CNT_W-1:0]    evt_index;
    logic                evt_overflow;

    modport master (
        output cfg_we, cfg_kind, cfg_idx, cfg_word, cfg_wdata, evt_ready,
        input  cfg_err, evt_valid, evt_chan, evt_index, evt_overflow
    );

    modport slave (
        input  cfg_we, cfg_kind, cfg_idx, cfg_word, cfg_wdata, evt_ready,
        output cfg_err, evt_valid, evt_chan, evt_index, evt_overflow
    );
endinterface

`default_nettype wire

// File: rtl/ltl_nfa_monitor_engine.sv
// ============================================================================
// Module  : ltl_nfa_monitor_engine
// Purpose : Runtime-programmable homogeneous NFA for LTL trace monitoring.
//           Each STE has a 2^SYMBOL_W-bit match set, a predecessor mask, a
//           start type and a report channel. One symbol is consumed per run
//           cycle; report pulses, sticky flags and a one-deep event buffer
//           are produced.
// Ports   : clk, reset        clock / sync active-high reset
//           run_i, restart_i  consume enable / clear run state, keep config
//           symbols_i         trace symbol
//           bus (slave)       config bus and report-event handshake
//           report_o          per-channel report for previous symbol
//           report_sticky_o   OR of reports since reset/restart
//           sym_index_o       saturating count of consumed symbols
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ltl_nfa_monitor_engine #(
    parameter int N_STE    = 16,
    parameter int SYMBOL_W = 8,
    parameter int N_REPORT = 4,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_i,
    input  logic                  restart_i,
    input  logic [SYMBOL_W-1:0]   symbols_i,
    ltl_nfa_monitor_engine_if.slave bus,
    output logic [N_REPORT-1:0]   report_o,
    output logic [N_REPORT-1:0]   report_sticky_o,
    output logic [CNT_W-1:0]      sym_index_o
);
    localparam int MW      = 1 << SYMBOL_W;
    localparam int N_WORDS = MW / 32;
    localparam int RW      = (N_REPORT > 1) ? $clog2(N_REPORT) : 1;

    localparam logic [1:0] START_SOD  = 2'd1;
    localparam logic [1:0] START_ALL  = 2'd2;
    localparam logic [1:0] KIND_MATCH = 2'd0;
    localparam logic [1:0] KIND_PRED  = 2'd1;
    localparam logic [1:0] KIND_ATTR  = 2'd2;
    localparam logic [1:0] KIND_RSVD  = 2'd3;

    // configuration
    logic [MW-1:0]    match_q  [N_STE];
    logic [N_STE-1:0] pred_q   [N_STE];
    logic [1:0]       start_q  [N_STE];
    logic             rep_en_q [N_STE];
    logic [RW-1:0]    chan_q   [N_STE];

    // run state
    logic [N_STE-1:0]    active_q, active_d;
    logic                sod_q;
    logic [N_REPORT-1:0] report_q, report_d, sticky_q;
    logic [CNT_W-1:0]    sym_index_q;
    logic                cfg_err_q;
    logic                evt_valid_q, evt_overflow_q;
    logic [N_REPORT-1:0] evt_chan_q;
    logic [CNT_W-1:0]    evt_index_q;

    logic             w_step;
    logic             w_reject;
    logic [N_STE-1:0] w_hit;

    // restart wins over run in the same cycle
    assign w_step = run_i & ~restart_i;

    always_comb begin
        w_reject = run_i
                 | (bus.cfg_kind == KIND_RSVD)
                 | (int'(bus.cfg_idx) >= N_STE)
                 | ((bus.cfg_kind == KIND_MATCH) && (int'(bus.cfg_word) >= N_WORDS));
    end

    for (genvar gi = 0; gi < N_STE; gi++) begin : g_ste
        logic w_enable;
        assign w_enable = (|(active_q & pred_q[gi]))
                        | ((start_q[gi] == START_SOD) & sod_q)
                        | (start_q[gi] == START_ALL);
        assign w_hit[gi] = w_enable & match_q[gi][symbols_i];
    end

    always_comb begin
        active_d = w_step ? w_hit : active_q;
        report_d = '0;
        if (w_step) begin
            for (int i = 0; i < N_STE; i++) begin
                for (int c = 0; c < N_REPORT; c++) begin
                    if (w_hit[i] && rep_en_q[i] && (int'(chan_q[i]) == c))
                        report_d[c] = 1'b1;
                end
            end
        end
    end

    // configuration storage; writes land on the edge that samples cfg_we
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_STE; i++) begin
                match_q[i]  <= '0;
                pred_q[i]   <= '0;
                start_q[i]  <= '0;
                rep_en_q[i] <= 1'b0;
                chan_q[i]   <= '0;
            end
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we & w_reject;
            if (bus.cfg_we && !w_reject) begin
                for (int i = 0; i < N_STE; i++) begin
                    if (int'(bus.cfg_idx) == i) begin
                        if (bus.cfg_kind == KIND_MATCH) begin
                            for (int w = 0; w < N_WORDS; w++) begin
                                if (int'(bus.cfg_word) == w)
                                    match_q[i][32*w +: 32] <= bus.cfg_wdata;
                            end
                        end
                        if (bus.cfg_kind == KIND_PRED)
                            pred_q[i] <= bus.cfg_wdata[N_STE-1:0];
                        if (bus.cfg_kind == KIND_ATTR) begin
                            start_q[i]  <= bus.cfg_wdata[1:0];
                            rep_en_q[i] <= bus.cfg_wdata[2];
                            chan_q[i]   <= bus.cfg_wdata[3 +: RW];
                        end
                    end
                end
            end
        end
    end

    // run state and event buffer
    always_ff @(posedge clk) begin
        if (reset || restart_i) begin
            active_q       <= '0;
            sod_q          <= 1'b1;
            report_q       <= '0;
            sticky_q       <= '0;
            sym_index_q    <= '0;
            evt_valid_q    <= 1'b0;
            evt_overflow_q <= 1'b0;
            if (reset) begin
                evt_chan_q  <= '0;
                evt_index_q <= '0;
            end
        end else begin
            active_q <= active_d;
            report_q <= report_d;
            sticky_q <= sticky_q | report_d;
            if (run_i) begin
                sod_q <= 1'b0;
                if (sym_index_q != '1)
                    sym_index_q <= sym_index_q + CNT_W'(1);
            end
            if (evt_valid_q && bus.evt_ready)
                evt_valid_q <= 1'b0;
            // report_q and sym_index_q were updated on the same edge, so
            // sym_index_q - 1 is the index of the symbol that reported
            if (report_q != '0) begin
                if (!evt_valid_q || bus.evt_ready) begin
                    evt_valid_q <= 1'b1;
                    evt_chan_q  <= report_q;
                    evt_index_q <= sym_index_q - CNT_W'(1);
                end else begin
                    evt_overflow_q <= 1'b1;
                end
            end
        end
    end

    assign report_o         = report_q;
    assign report_sticky_o  = sticky_q;
    assign sym_index_o      = sym_index_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.evt_valid    = evt_valid_q;
    assign bus.evt_chan     = evt_chan_q;
    assign bus.evt_index    = evt_index_q;
    assign bus.evt_overflow = evt_overflow_q;
endmodule

`default_nettype wire
